// File: rtl/scalar_mult_seq.sv
// Purpose : sequences one Ed25519 scalar multiplication R = m*P over the shared
//           point datapath (LOAD, then DBL/ADD per scalar bit MSB->LSB, INV, NORM).
// Latency : every command costs >= 1 issue cycle + >= 1 wait cycle; a job is
//           1 + 2*SCALAR_W + 2 commands (constant time) or 1 + SCALAR_W + popcount(m) + 2.
// Backpressure: command held (valid/code/keep stable) until i_op_ready; the next
//           command issues only after i_op_done; DONE holds until i_done_ack.
//
// Ports:
//   i_clk, i_rst_n               clock, synchronous active-low reset
//   i_start, i_scalar            job request and scalar m (taken only in IDLE)
//   i_abort                      abandon the current job (any non-IDLE state)
//   o_op_valid/i_op_ready        command handshake; o_op_code, o_op_keep carried with it
//   i_op_done                    one-cycle pulse when the accepted command finishes
//   o_bit_idx                    scalar bit currently being processed
//   o_busy, o_done/i_done_ack    job status and result hand-off
module scalar_mult_seq #(
    parameter int SCALAR_W   = 256,
    parameter bit CONST_TIME = 1'b1
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_start,
    input  logic [SCALAR_W-1:0]         i_scalar,
    input  logic                        i_abort,
    output logic                        o_busy,
    output logic                        o_op_valid,
    input  logic                        i_op_ready,
    output logic [2:0]                  o_op_code,
    output logic                        o_op_keep,
    input  logic                        i_op_done,
    output logic [$clog2(SCALAR_W)-1:0] o_bit_idx,
    output logic                        o_done,
    input  logic                        i_done_ack
);

    localparam int IDX_W = $clog2(SCALAR_W);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_DBL  = 3'd2,
        ST_ADD  = 3'd3,
        ST_INV  = 3'd4,
        ST_NORM = 3'd5,
        ST_DONE = 3'd6
    } state_t;

    localparam logic [2:0] OP_LOAD = 3'd0;
    localparam logic [2:0] OP_DBL  = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_INV  = 3'd3;
    localparam logic [2:0] OP_NORM = 3'd4;

    state_t                state_q, state_d;
    logic                  wait_q, wait_d;      // 0 = ISSUE phase, 1 = WAIT phase
    logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
    logic [SCALAR_W-1:0]   scalar_q, scalar_d;

    logic cur_bit;
    logic last_bit;

    assign cur_bit  = scalar_q[bit_idx_q];
    assign last_bit = (bit_idx_q == '0);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            wait_q    <= 1'b0;
            bit_idx_q <= '0;
            scalar_q  <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            bit_idx_q <= bit_idx_d;
            scalar_q  <= scalar_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        bit_idx_d = bit_idx_q;
        scalar_d  = scalar_q;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d   = ST_LOAD;
                    wait_d    = 1'b0;
                    scalar_d  = i_scalar;
                    bit_idx_d = IDX_W'(SCALAR_W - 1);
                end
            end
            ST_DONE: begin
                // a start in the ack cycle is deliberately not looked at here
                if (i_done_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                if (!wait_q) begin
                    if (i_op_ready) begin
                        wait_d = 1'b1;
                    end
                end else if (i_op_done) begin
                    // done is only meaningful in WAIT; the next ISSUE starts next cycle
                    wait_d = 1'b0;
                    case (state_q)
                        ST_LOAD: state_d = ST_DBL;
                        ST_DBL: begin
                            if (CONST_TIME || cur_bit) begin
                                state_d = ST_ADD;
                            end else if (last_bit) begin
                                state_d = ST_INV;
                            end else begin
                                state_d   = ST_DBL;
                                bit_idx_d = bit_idx_q - 1'b1;
                            end
                        end
                        ST_ADD: begin
                            if (last_bit) begin
                                state_d = ST_INV;
                            end else begin
                                state_d   = ST_DBL;
                                bit_idx_d = bit_idx_q - 1'b1;
                            end
                        end
                        ST_INV:  state_d = ST_NORM;
                        ST_NORM: state_d = ST_DONE;
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
        endcase

        // abort overrides every other transition; a late done then lands in IDLE
        if (i_abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            wait_d  = 1'b0;
        end
    end

    always_comb begin
        o_busy     = (state_q != ST_IDLE);
        o_done     = (state_q == ST_DONE);
        o_bit_idx  = bit_idx_q;
        o_op_valid = 1'b0;
        o_op_code  = OP_LOAD;
        o_op_keep  = 1'b0;
        case (state_q)
            ST_LOAD: begin
                o_op_valid = !wait_q;
                o_op_code  = OP_LOAD;
            end
            ST_DBL: begin
                o_op_valid = !wait_q;
                o_op_code  = OP_DBL;
            end
            ST_ADD: begin
                o_op_valid = !wait_q;
                o_op_code  = OP_ADD;
                o_op_keep  = cur_bit;   // 0 = dummy add in constant-time mode
            end
            ST_INV: begin
                o_op_valid = !wait_q;
                o_op_code  = OP_INV;
            end
            ST_NORM: begin
                o_op_valid = !wait_q;
                o_op_code  = OP_NORM;
            end
            default: begin
                o_op_valid = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_scalar_mult_seq.sv
module tb_scalar_mult_seq;

    localparam int SW = 256;
    localparam int IW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n[2];
    logic          start[2];
    logic [SW-1:0] scalar[2];
    logic          abort_s[2];
    logic          op_ready[2];
    logic          op_done[2];
    logic          done_ack[2];
    logic          busy_o[2];
    logic          valid_o[2];
    logic [2:0]    code_o[2];
    logic          keep_o[2];
    logic [IW-1:0] idx_o[2];
    logic          done_o[2];

    scalar_mult_seq #(.SCALAR_W(SW), .CONST_TIME(1'b1)) dut_ct (
        .i_clk(clk), .i_rst_n(rst_n[0]), .i_start(start[0]), .i_scalar(scalar[0]),
        .i_abort(abort_s[0]), .o_busy(busy_o[0]), .o_op_valid(valid_o[0]),
        .i_op_ready(op_ready[0]), .o_op_code(code_o[0]), .o_op_keep(keep_o[0]),
        .i_op_done(op_done[0]), .o_bit_idx(idx_o[0]), .o_done(done_o[0]),
        .i_done_ack(done_ack[0])
    );

    scalar_mult_seq #(.SCALAR_W(SW), .CONST_TIME(1'b0)) dut_nc (
        .i_clk(clk), .i_rst_n(rst_n[1]), .i_start(start[1]), .i_scalar(scalar[1]),
        .i_abort(abort_s[1]), .o_busy(busy_o[1]), .o_op_valid(valid_o[1]),
        .i_op_ready(op_ready[1]), .o_op_code(code_o[1]), .o_op_keep(keep_o[1]),
        .i_op_done(op_done[1]), .o_bit_idx(idx_o[1]), .o_done(done_o[1]),
        .i_done_ack(done_ack[1])
    );

    int total = 0;
    int bad   = 0;
    int proto_err = 0;
    logic [11:0] rec[$];     // {code, bit_idx, keep} per accepted command
    logic [11:0] exp_q[$];

    task automatic check(input string tag, input longint got, input longint expv);
        total++;
        assert (got === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference command stream: LOAD, per bit DBL then (ADD if constant time or bit set), INV, NORM.
    task automatic build_exp(input logic [SW-1:0] m, input bit ct);
        logic [7:0] ib;
        exp_q.delete();
        exp_q.push_back({3'd0, 8'd255, 1'b0});
        for (int i = SW - 1; i >= 0; i--) begin
            ib = i[7:0];
            exp_q.push_back({3'd1, ib, 1'b0});
            if (ct || m[i]) exp_q.push_back({3'd2, ib, m[i]});
        end
        exp_q.push_back({3'd3, 8'd0, 1'b0});
        exp_q.push_back({3'd4, 8'd0, 1'b0});
    endtask

    task automatic compare(input string tag);
        int nm;
        nm = 0;
        check({tag, "_count"}, rec.size(), exp_q.size());
        for (int i = 0; i < rec.size() && i < exp_q.size(); i++)
            if (rec[i] !== exp_q[i]) nm++;
        check({tag, "_seq_mismatches"}, nm, 0);
    endtask

    // Serve one command: hold ready low for 'hold' cycles, accept, then done one cycle later.
    task automatic step_cmd(input int k, input int hold);
        int w;
        logic [2:0] c;
        logic [7:0] i;
        logic kp;
        w = 0;
        while (!valid_o[k] && w < 50) begin
            tick();
            w++;
        end
        if (!valid_o[k]) begin
            check("valid_timeout", 0, 1);
            return;
        end
        c  = code_o[k];
        i  = idx_o[k];
        kp = (c == 3'd2) ? keep_o[k] : 1'b0;
        for (int h = 0; h <= hold; h++) begin
            op_ready[k] = (h == hold);
            if (!valid_o[k] || code_o[k] !== c || idx_o[k] !== i ||
                (c == 3'd2 && keep_o[k] !== kp)) proto_err++;
            tick();
        end
        op_ready[k] = 1'b0;
        if (valid_o[k] !== 1'b0) proto_err++;
        op_done[k] = 1'b1;
        tick();
        op_done[k] = 1'b0;
        rec.push_back({c, i, kp});
    endtask

    task automatic run_job(input int k);
        int n;
        n = 0;
        while (!done_o[k] && n < 600) begin
            step_cmd(k, 0);
            n++;
        end
        check("done_reached", done_o[k], 1);
        check("busy_in_done", busy_o[k], 1);
    endtask

    task automatic start_job(input int k, input logic [SW-1:0] m);
        scalar[k] = m;
        start[k]  = 1'b1;
        tick();
        start[k]  = 1'b0;
        rec.delete();
        proto_err = 0;
    endtask

    task automatic ack(input int k);
        done_ack[k] = 1'b1;
        tick();
        done_ack[k] = 1'b0;
        check("idle_after_ack", busy_o[k], 0);
        check("done_low_after_ack", done_o[k], 0);
    endtask

    initial begin
        int n_add;
        int n;
        logic [SW-1:0] m5, mb, m_all, m1;
        m5    = '0; m5[2] = 1'b1; m5[0] = 1'b1;
        mb    = '0; mb[200] = 1'b1; mb[3] = 1'b1; mb[0] = 1'b1;
        m_all = '1;
        m1    = '0; m1[0] = 1'b1;

        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b0; start[k] = 1'b0; scalar[k] = m_all; abort_s[k] = 1'b0;
            op_ready[k] = 1'b0; op_done[k] = 1'b0; done_ack[k] = 1'b0;
        end
        tick();
        tick();
        for (int k = 0; k < 2; k++) begin
            check("rst_busy", busy_o[k], 0);
            check("rst_valid", valid_o[k], 0);
            check("rst_code", code_o[k], 0);
            check("rst_keep", keep_o[k], 0);
            check("rst_idx", idx_o[k], 0);
            check("rst_done", done_o[k], 0);
        end
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        tick();

        // constant-time job, m = 5
        start_job(0, m5);
        check("load_code", code_o[0], 0);
        check("load_idx", idx_o[0], 255);
        run_job(0);
        check("ct_cmds", rec.size(), 515);
        n_add = 0;
        foreach (rec[i]) if (rec[i][11:9] == 3'd2 && rec[i][0]) n_add++;
        check("ct_kept_adds", n_add, 2);
        build_exp(m5, 1'b1);
        compare("ct_m5");
        check("ct_proto", proto_err, 0);
        check("idx_after_job", idx_o[0], 0);
        ack(0);

        // variable-time job, m = 5
        start_job(1, m5);
        run_job(1);
        check("nc_cmds", rec.size(), 261);
        n_add = 0;
        foreach (rec[i]) if (rec[i][11:9] == 3'd2) n_add++;
        check("nc_adds", n_add, 2);
        build_exp(m5, 1'b0);
        compare("nc_m5");
        check("nc_proto", proto_err, 0);
        ack(1);

        // reset mid-job on the variable-time instance
        start_job(1, m5);
        step_cmd(1, 0);
        step_cmd(1, 0);
        rst_n[1] = 1'b0;
        tick();
        check("midrst_busy", busy_o[1], 0);
        check("midrst_valid", valid_o[1], 0);
        check("midrst_idx", idx_o[1], 0);
        rst_n[1] = 1'b1;
        tick();

        // stall on DBL 200, early done during ADD issue, start while busy
        start_job(0, mb);
        n = 0;
        while (!(valid_o[0] && code_o[0] == 3'd1 && idx_o[0] == 8'd200) && n < 300) begin
            step_cmd(0, 0);
            n++;
        end
        check("reach_dbl200_code", code_o[0], 1);
        check("reach_dbl200_idx", idx_o[0], 200);
        step_cmd(0, 5);
        check("stall_proto", proto_err, 0);
        check("add200_code", code_o[0], 2);
        op_done[0] = 1'b1;
        tick();
        op_done[0] = 1'b0;
        check("early_done_valid", valid_o[0], 1);
        check("early_done_code", code_o[0], 2);
        check("early_done_idx", idx_o[0], 200);
        check("early_done_keep", keep_o[0], 1);
        scalar[0] = m_all;
        start[0]  = 1'b1;
        tick();
        start[0]  = 1'b0;
        check("busy_start_code", code_o[0], 2);
        check("busy_start_idx", idx_o[0], 200);
        step_cmd(0, 0);
        check("after_add_code", code_o[0], 1);
        check("after_add_idx", idx_o[0], 199);
        run_job(0);
        build_exp(mb, 1'b1);
        compare("stall_job");
        check("stall_job_proto", proto_err, 0);

        // start in the ack cycle is ignored; accepted the cycle after
        done_ack[0] = 1'b1;
        start[0]    = 1'b1;
        scalar[0]   = m_all;
        tick();
        done_ack[0] = 1'b0;
        check("ackstart_busy", busy_o[0], 0);
        check("ackstart_done", done_o[0], 0);
        tick();
        start[0] = 1'b0;
        check("restart_busy", busy_o[0], 1);
        check("restart_valid", valid_o[0], 1);
        check("restart_code", code_o[0], 0);
        check("restart_idx", idx_o[0], 255);

        // abort in WAIT of DBL 100, followed by a stale done
        n = 0;
        while (!(valid_o[0] && code_o[0] == 3'd1 && idx_o[0] == 8'd100) && n < 400) begin
            step_cmd(0, 0);
            n++;
        end
        check("reach_dbl100_idx", idx_o[0], 100);
        op_ready[0] = 1'b1;
        tick();
        op_ready[0] = 1'b0;
        check("wait_valid", valid_o[0], 0);
        check("wait_busy", busy_o[0], 1);
        abort_s[0] = 1'b1;
        tick();
        abort_s[0] = 1'b0;
        check("abort_busy", busy_o[0], 0);
        check("abort_valid", valid_o[0], 0);
        check("abort_done", done_o[0], 0);
        op_done[0] = 1'b1;
        tick();
        op_done[0] = 1'b0;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (valid_o[0] || busy_o[0]) n++;
            tick();
        end
        check("stale_done_quiet", n, 0);

        // fresh job m = 1 runs from bit 255
        start_job(0, m1);
        check("fresh_idx", idx_o[0], 255);
        run_job(0);
        check("fresh_cmds", rec.size(), 515);
        build_exp(m1, 1'b1);
        compare("fresh_m1");
        check("fresh_proto", proto_err, 0);
        ack(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
